// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared types, width helpers and default taps for cic_comp_fir
// Contents:
//   state_t        FSM state encoding {IDLE, MAC, ROUND, OUT}
//   clog2()        ceil(log2(value)); 0 for value <= 1
//   acc_dw()       accumulator width INP_DW + COEF_DW + clog2(NUM_TAPS)
//   DEFAULT_COEFS  21-tap inverse-sinc compensation set, 18-bit Q17, tap 0 in the LSBs
package cic_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // Sum of num_taps full-scale products needs clog2(num_taps) guard bits.
    function automatic int acc_dw(input int inp_dw, input int coef_dw, input int num_taps);
        return inp_dw + coef_dw + clog2(num_taps);
    endfunction

    localparam int DEFAULT_NUM_TAPS = 21;
    localparam int DEFAULT_COEF_DW  = 18;

    // Symmetric inverse-sinc shape: strong centre tap with alternating sidelobes.
    localparam logic [DEFAULT_NUM_TAPS*DEFAULT_COEF_DW-1:0] DEFAULT_COEFS = {
        18'sd10,    -18'sd20,   18'sd41,    -18'sd82,   18'sd164,
        -18'sd328,  18'sd655,   -18'sd1311, 18'sd3277,  -18'sd9830,
        18'sd98304,
        -18'sd9830, 18'sd3277,  -18'sd1311, 18'sd655,   -18'sd328,
        18'sd164,   -18'sd82,   18'sd41,    -18'sd20,   18'sd10
    };

endpackage

// File: rtl/cic_comp_fir_mac.sv
// rtl/cic_comp_fir_mac.sv - product register, accumulator and round/shift/saturate for cic_comp_fir
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   clr           clears product pipeline and accumulator (start of a new output)
//   en            register sample*coef this cycle; it is accumulated on the next cycle
//   sample, coef  signed operands
//   acc_out       running accumulator
//   sat_out       acc_out rounded, shifted right by OUT_SHIFT and saturated to OUT_DW
module cic_comp_mac #(
    parameter int INP_DW    = 32,
    parameter int COEF_DW   = 18,
    parameter int ACC_DW    = 55,
    parameter int OUT_DW    = 32,
    parameter int OUT_SHIFT = 17
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic signed [INP_DW-1:0]  sample,
    input  logic signed [COEF_DW-1:0] coef,
    output logic signed [ACC_DW-1:0]  acc_out,
    output logic signed [OUT_DW-1:0]  sat_out
);

    localparam int PROD_DW = INP_DW + COEF_DW;
    // One extra bit so the rounding offset can never wrap the accumulator value.
    localparam int RW      = ACC_DW + 1;
    localparam int RND_SH  = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND = (OUT_SHIFT > 0) ? (RW'(1) << RND_SH) : '0;

    logic signed [PROD_DW-1:0] prod;
    logic                      prod_vld;
    logic signed [RW-1:0]      rnd;
    logic signed [RW-1:0]      shifted;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc_out  <= '0;
        end else begin
            prod_vld <= en;
            if (en) begin
                prod <= sample * coef;
            end
            if (prod_vld) begin
                acc_out <= acc_out + ACC_DW'(prod);
            end
        end
    end

    always_comb begin
        rnd     = RW'(acc_out) + RND;
        shifted = rnd >>> OUT_SHIFT;
    end

    generate
        if (OUT_DW < RW) begin : g_sat
            always_comb begin
                // In range when every bit above the output sign bit matches it.
                if ((&shifted[RW-1:OUT_DW-1]) || !(|shifted[RW-1:OUT_DW-1])) begin
                    sat_out = shifted[OUT_DW-1:0];
                end else if (shifted[RW-1]) begin
                    sat_out = {1'b1, {(OUT_DW-1){1'b0}}};
                end else begin
                    sat_out = {1'b0, {(OUT_DW-1){1'b1}}};
                end
            end
        end else begin : g_nosat
            assign sat_out = OUT_DW'(shifted);
        end
    endgenerate

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - sequential single-multiplier CIC droop-compensation FIR with optional decimation
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   s_axis_in_tdata    signed input sample (INP_DW)
//   s_axis_in_tvalid   input valid
//   s_axis_in_tready   high while idle; a sample can be accepted
//   m_axis_out_tdata   signed filtered sample (OUT_DW), held between valids
//   m_axis_out_tvalid  one-cycle output strobe, NUM_TAPS+3 cycles after the FIR_R-th accept
//   overflow           one-cycle pulse when a sample arrives while busy and is dropped
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int                            INP_DW    = 32,
    parameter int                            OUT_DW    = 32,
    parameter int                            COEF_DW   = 18,
    parameter int                            NUM_TAPS  = 21,
    parameter logic [NUM_TAPS*COEF_DW-1:0]   COEFS     = '0,
    parameter int                            OUT_SHIFT = 17,
    parameter int                            FIR_R     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [INP_DW-1:0] s_axis_in_tdata,
    input  logic                     s_axis_in_tvalid,
    output logic                     s_axis_in_tready,
    output logic signed [OUT_DW-1:0] m_axis_out_tdata,
    output logic                     m_axis_out_tvalid,
    output logic                     overflow
);

    localparam int ACC_DW = acc_dw(INP_DW, COEF_DW, NUM_TAPS);
    localparam int PTR_W  = clog2(NUM_TAPS);
    // k runs to NUM_TAPS inclusive: the extra step lets the last product accumulate.
    localparam int KW     = clog2(NUM_TAPS + 1);
    localparam int PH_W   = (FIR_R > 1) ? clog2(FIR_R) : 1;

    state_t                    state;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [KW-1:0]             k;
    logic [PH_W-1:0]           phase;
    logic signed [INP_DW-1:0]  dline [NUM_TAPS];
    logic signed [COEF_DW-1:0] coef_rom [NUM_TAPS];

    logic                      accept;
    logic                      start;
    logic                      mac_en;
    logic signed [INP_DW-1:0]  mac_sample;
    logic signed [COEF_DW-1:0] mac_coef;
    logic signed [ACC_DW-1:0]  acc_unused;
    logic signed [OUT_DW-1:0]  sat;

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coef
        assign coef_rom[g] = COEFS[COEF_DW*g +: COEF_DW];
    end

    assign s_axis_in_tready = (state == IDLE);
    assign overflow         = s_axis_in_tvalid && !s_axis_in_tready;
    assign accept           = s_axis_in_tvalid && s_axis_in_tready;
    assign start            = accept && (phase == PH_W'(FIR_R - 1));
    assign mac_en           = (state == MAC) && (k < KW'(NUM_TAPS));
    assign mac_sample       = dline[rd_ptr];
    assign mac_coef         = coef_rom[k[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            k                 <= '0;
            phase             <= '0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                dline[i] <= '0;
            end
        end else begin
            m_axis_out_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dline[wr_ptr] <= s_axis_in_tdata;
                        wr_ptr <= (wr_ptr == PTR_W'(NUM_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
                        phase  <= (phase == PH_W'(FIR_R - 1)) ? '0 : phase + 1'b1;
                        if (start) begin
                            // Newest sample sits at the write address; walk backwards from it.
                            rd_ptr <= wr_ptr;
                            k      <= '0;
                            state  <= MAC;
                        end
                    end
                end
                MAC: begin
                    rd_ptr <= (rd_ptr == '0) ? PTR_W'(NUM_TAPS - 1) : rd_ptr - 1'b1;
                    if (k == KW'(NUM_TAPS)) begin
                        state <= ROUND;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ROUND: begin
                    m_axis_out_tdata  <= sat;
                    m_axis_out_tvalid <= 1'b1;
                    state             <= OUT;
                end
                OUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cic_comp_mac #(
        .INP_DW   (INP_DW),
        .COEF_DW  (COEF_DW),
        .ACC_DW   (ACC_DW),
        .OUT_DW   (OUT_DW),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_mac (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (start),
        .en     (mac_en),
        .sample (mac_sample),
        .coef   (mac_coef),
        .acc_out(acc_unused),
        .sat_out(sat)
    );

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - scoreboard bench for cic_comp_fir over four parameter sets
module tb_cic_comp_fir;

    localparam logic [89:0] CO_A = {18'd1, 18'd2, 18'd3, 18'd2, 18'd1};
    localparam logic [89:0] CO_C = {18'd1, 18'd1, 18'd1, 18'd1, 18'd1};
    localparam logic [53:0] CO_D = {18'd0, 18'd0, 18'd1};

    typedef struct {
        int     id;
        int     data;
        longint due;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [31:0] din  [4];
    logic               vin  [4];
    logic               rdy  [4];
    logic signed [31:0] dout [4];
    logic               vout [4];
    logic               ovf  [4];
    logic signed [7:0]  c_dout;

    exp_t   sbq[$];
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     lat [4] = '{8, 8, 8, 6};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign dout[2] = {{24{c_dout[7]}}, c_dout};

    cic_comp_fir #(.NUM_TAPS(5), .COEFS(CO_A), .OUT_SHIFT(0), .FIR_R(1)) u_a (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[0]), .s_axis_in_tvalid(vin[0]), .s_axis_in_tready(rdy[0]),
        .m_axis_out_tdata(dout[0]), .m_axis_out_tvalid(vout[0]), .overflow(ovf[0]));

    cic_comp_fir #(.NUM_TAPS(5), .COEFS(CO_A), .OUT_SHIFT(0), .FIR_R(2)) u_b (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[1]), .s_axis_in_tvalid(vin[1]), .s_axis_in_tready(rdy[1]),
        .m_axis_out_tdata(dout[1]), .m_axis_out_tvalid(vout[1]), .overflow(ovf[1]));

    cic_comp_fir #(.OUT_DW(8), .NUM_TAPS(5), .COEFS(CO_C), .OUT_SHIFT(0), .FIR_R(1)) u_c (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[2]), .s_axis_in_tvalid(vin[2]), .s_axis_in_tready(rdy[2]),
        .m_axis_out_tdata(c_dout), .m_axis_out_tvalid(vout[2]), .overflow(ovf[2]));

    cic_comp_fir #(.NUM_TAPS(3), .COEFS(CO_D), .OUT_SHIFT(1), .FIR_R(1)) u_d (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[3]), .s_axis_in_tvalid(vin[3]), .s_axis_in_tready(rdy[3]),
        .m_axis_out_tdata(dout[3]), .m_axis_out_tvalid(vout[3]), .overflow(ovf[3]));

    task automatic chk(input string name, input longint got, input longint req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic send(input int id, input int x, input bit has_out, input int y);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (!rdy[id] && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!rdy[id]) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d got=busy required=ready", id);
        end else begin
            din[id] = x;
            vin[id] = 1'b1;
            if (has_out) begin
                e.id   = id;
                e.data = y;
                e.due  = cyc + longint'(lat[id]);
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            vin[id] = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk(name, sbq.size(), 0);
        sbq.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every output strobe must match the oldest expectation, including its due cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (vout[i]) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out dut%0d got=%0d required=none", i, dout[i]);
                end else begin
                    e = sbq.pop_front();
                    if (e.id != i || dout[i] != e.data || cyc != e.due) begin
                        bad++;
                        $display("FAIL out dut%0d got=%0d@%0d required=dut%0d %0d@%0d",
                                 i, dout[i], cyc, e.id, e.data, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bp_y [3];
        exp_t e;
        bp_y = '{10, 120, 420};
        for (int i = 0; i < 4; i++) begin
            din[i] = '0;
            vin[i] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tready%0d", i), rdy[i], 1);
            chk($sformatf("rst_tvalid%0d", i), vout[i], 0);
            chk($sformatf("rst_tdata%0d", i), dout[i], 0);
            chk($sformatf("rst_overflow%0d", i), ovf[i], 0);
        end

        // Impulse, no decimation
        send(0, 100, 1, 100);
        send(0, 0, 1, 200);
        send(0, 0, 1, 300);
        send(0, 0, 1, 200);
        send(0, 0, 1, 100);
        send(0, 0, 1, 0);
        drain("drain_impulse");

        // Impulse, decimate by 2: only odd-indexed samples produce output
        send(1, 100, 0, 0);
        send(1, 0, 1, 200);
        send(1, 0, 0, 0);
        send(1, 0, 1, 200);
        send(1, 0, 0, 0);
        send(1, 0, 1, 0);
        drain("drain_decim");

        // Saturation to 8-bit output
        for (int i = 0; i < 5; i++) send(2, 127, 1, 127);
        send(2, -128, 1, 127);
        send(2, -128, 1, 125);
        send(2, -128, 1, -128);
        send(2, -128, 1, -128);
        send(2, -128, 1, -128);
        drain("drain_sat");

        // Round half up then shift right by one
        send(3, 1, 1, 1);
        send(3, -1, 1, 0);
        send(3, 3, 1, 2);
        drain("drain_round");

        // Back-pressure: tvalid held for 20 cycles
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            din[0] = (i + 1) * 10;
            vin[0] = 1'b1;
            #1;
            chk($sformatf("bp_tready%0d", i), rdy[0], (i % 9 == 0) ? 1 : 0);
            chk($sformatf("bp_overflow%0d", i), ovf[0], (i % 9 == 0) ? 0 : 1);
            if (i % 9 == 0) begin
                e.id   = 0;
                e.data = bp_y[i / 9];
                e.due  = cyc + 8;
                sbq.push_back(e);
            end
        end
        @(negedge clk);
        vin[0] = 1'b0;
        drain("drain_bp");

        // Reset during MAC aborts the computation and clears the delay line
        send(0, 100, 0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (vout[0]) cnt++;
        end
        chk("rst_mid_no_tvalid", cnt, 0);
        chk("rst_mid_tdata", dout[0], 0);
        send(0, 50, 1, 50);
        send(0, 0, 1, 100);
        send(0, 0, 1, 150);
        send(0, 0, 1, 100);
        send(0, 0, 1, 50);
        drain("drain_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
